// File: rtl/siso_pkg.sv
// Shared trellis definitions for the 4-state (7,5) RSC max-log-MAP decoder.
// Path-metric arithmetic is carried out in int and clamped back to the register width.
package siso_pkg;

  localparam int NUM_STATES = 4;
  localparam int DEF_W      = 8;
  localparam int DEF_AW     = DEF_W + 4;
  localparam int NEG_INF    = -(2 ** (DEF_AW - 2));

  typedef logic signed [DEF_AW-1:0] metric_t;

  typedef enum logic [1:0] {IDLE, LOAD, BWD, DONE} state_t;

  function automatic logic [1:0] next_state(input logic [1:0] s, input logic u);
    logic a;
    a = u ^ s[1] ^ s[0];
    return {a, s[1]};
  endfunction

  function automatic logic parity(input logic [1:0] s, input logic u);
    logic a;
    a = u ^ s[1] ^ s[0];
    return a ^ s[0];
  endfunction

  function automatic int neg_inf(input int aw);
    return -(2 ** (aw - 2));
  endfunction

  // sym=1 clamps to the symmetric range so the most negative code never appears
  function automatic int sat(input int x, input int w, input logic sym);
    int hi;
    int lo;
    hi = (2 ** (w - 1)) - 1;
    lo = sym ? -hi : -(2 ** (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic int branch(input logic u, input logic p, input int lsa, input int lp);
    return (u ? lsa : 0) + (p ? lp : 0);
  endfunction

endpackage

// File: rtl/siso_acs.sv
// Combinational 4-state add-compare-select with state-0 normalisation.
// dir=0 runs the forward (alpha) recursion, dir=1 the backward (beta) recursion.
module siso_acs
  import siso_pkg::*;
#(
  parameter int W  = 8,
  parameter int AW = W + 4
) (
  input  logic                 dir,
  input  logic signed [W-1:0]  ls,
  input  logic signed [W-1:0]  lp,
  input  logic signed [W-1:0]  la,
  input  logic signed [AW-1:0] m_in  [NUM_STATES],
  output logic signed [AW-1:0] m_out [NUM_STATES]
);

  int         acc [NUM_STATES];
  int         lsa;
  int         cand;
  logic [1:0] src;
  logic [1:0] dst;

  // Forward scatters each source into its successor; backward gathers from successors.
  always_comb begin
    lsa  = int'(ls) + int'(la);
    cand = 0;
    src  = '0;
    dst  = '0;
    for (int i = 0; i < NUM_STATES; i++) acc[i] = -(2 ** 30);
    for (int s = 0; s < NUM_STATES; s++) begin
      for (int u = 0; u < 2; u++) begin
        src  = 2'(s);
        dst  = next_state(src, 1'(u));
        cand = branch(1'(u), parity(src, 1'(u)), lsa, int'(lp));
        if (!dir) begin
          cand = cand + int'(m_in[src]);
          if (cand > acc[dst]) acc[dst] = cand;
        end else begin
          cand = cand + int'(m_in[dst]);
          if (cand > acc[src]) acc[src] = cand;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_STATES; i++) m_out[i] = AW'(sat(acc[i] - acc[0], AW, 1'b0));
  end

endmodule

// File: rtl/siso_maxlog.sv
// Max-log-MAP soft-in/soft-out decoder for one RSC constituent code: forward pass while
// loading, then a backward pass that emits extrinsic LLRs for indices N-1 down to 0.
module siso_maxlog
  import siso_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 16,
  parameter int AW = W + 4,
  parameter int IW = $clog2(N)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_valid,
  input  logic signed [W-1:0] i_sys,
  input  logic signed [W-1:0] i_par,
  input  logic signed [W-1:0] i_apr,
  output logic                o_ready,
  output logic                o_valid,
  output logic signed [W-1:0] o_ext,
  output logic                o_bit,
  output logic [IW-1:0]       o_idx,
  output logic                o_busy,
  output logic                o_done
);

  state_t               state;
  state_t               state_nxt;
  logic [IW-1:0]        cnt;
  logic                 accept;
  logic                 last_in;
  logic                 last_out;
  logic signed [AW-1:0] alpha     [NUM_STATES];
  logic signed [AW-1:0] alpha_nxt [NUM_STATES];
  logic signed [AW-1:0] beta      [NUM_STATES];
  logic signed [AW-1:0] beta_nxt  [NUM_STATES];
  logic signed [W-1:0]  sys_mem   [N];
  logic signed [W-1:0]  par_mem   [N];
  logic signed [W-1:0]  apr_mem   [N];
  logic signed [AW-1:0] alpha_mem [N][NUM_STATES];
  int                   lsa_k;
  int                   cand;
  int                   best0;
  int                   best1;
  int                   lapp;
  int                   ext_val;
  logic [1:0]           src;
  logic [1:0]           dst;

  assign accept   = (state == LOAD) && i_valid;
  assign last_in  = (cnt == IW'(N - 1));
  assign last_out = (cnt == '0);
  assign o_ready  = (state == LOAD);
  assign o_busy   = (state != IDLE);

  siso_acs #(.W(W), .AW(AW)) u_fwd (
    .dir   (1'b0),
    .ls    (i_sys),
    .lp    (i_par),
    .la    (i_apr),
    .m_in  (alpha),
    .m_out (alpha_nxt)
  );

  siso_acs #(.W(W), .AW(AW)) u_bwd (
    .dir   (1'b1),
    .ls    (sys_mem[cnt]),
    .lp    (par_mem[cnt]),
    .la    (apr_mem[cnt]),
    .m_in  (beta),
    .m_out (beta_nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = LOAD;
      LOAD:    if (accept && last_in) state_nxt = BWD;
      BWD:     if (last_out) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A-posteriori LLR at index cnt from stored alpha_k, current beta_{k+1} and stored samples.
  always_comb begin
    best0 = -(2 ** 30);
    best1 = -(2 ** 30);
    cand  = 0;
    src   = '0;
    dst   = '0;
    lsa_k = int'(sys_mem[cnt]) + int'(apr_mem[cnt]);
    for (int s = 0; s < NUM_STATES; s++) begin
      for (int u = 0; u < 2; u++) begin
        src  = 2'(s);
        dst  = next_state(src, 1'(u));
        cand = int'(alpha_mem[cnt][src]) + int'(beta[dst])
             + branch(1'(u), parity(src, 1'(u)), lsa_k, int'(par_mem[cnt]));
        if (u == 1) begin
          if (cand > best1) best1 = cand;
        end else begin
          if (cand > best0) best0 = cand;
        end
      end
    end
    lapp    = best1 - best0;
    ext_val = sat(lapp - lsa_k, W, 1'b1);
  end

  // Sample and alpha storage carry no reset; every location is rewritten before it is read.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      sys_mem[cnt] <= i_sys;
      par_mem[cnt] <= i_par;
      apr_mem[cnt] <= i_apr;
      for (int i = 0; i < NUM_STATES; i++) alpha_mem[cnt][i] <= alpha[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      o_valid <= 1'b0;
      o_ext   <= '0;
      o_bit   <= 1'b0;
      o_idx   <= '0;
      o_done  <= 1'b0;
      for (int i = 0; i < NUM_STATES; i++) begin
        alpha[i] <= '0;
        beta[i]  <= '0;
      end
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            cnt      <= '0;
            alpha[0] <= '0;
            for (int i = 1; i < NUM_STATES; i++) alpha[i] <= AW'(neg_inf(AW));
            for (int i = 0; i < NUM_STATES; i++) beta[i] <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            for (int i = 0; i < NUM_STATES; i++) alpha[i] <= alpha_nxt[i];
            // Holding at N-1 hands the backward pass its starting index.
            cnt <= last_in ? cnt : cnt + 1'b1;
          end
        end
        BWD: begin
          o_valid <= 1'b1;
          o_ext   <= W'(ext_val);
          o_bit   <= (lapp > 0);
          o_idx   <= cnt;
          cnt     <= cnt - 1'b1;
          for (int i = 0; i < NUM_STATES; i++) beta[i] <= beta_nxt[i];
        end
        DONE: begin
          o_valid <= 1'b0;
          o_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_siso_maxlog.sv
// Directed bench for siso_maxlog: a frame-level max-log-MAP model predicts every output,
// with hand-derived literals pinning the encoder and the model's first extrinsic values.
module tb_siso_maxlog;

  localparam int W   = 8;
  localparam int N   = 16;
  localparam int AW  = W + 4;
  localparam int IW  = $clog2(N);
  localparam int NEG = -(2 ** (AW - 2));

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                valid;
  logic signed [W-1:0] sys;
  logic signed [W-1:0] par;
  logic signed [W-1:0] apr;
  logic                ready;
  logic                out_valid;
  logic signed [W-1:0] ext;
  logic                hard;
  logic [IW-1:0]       idx;
  logic                busy;
  logic                done;

  typedef struct {
    int ext;
    int hard;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  int   fr_sys [N];
  int   fr_par [N];
  int   fr_apr [N];
  int   enc_par[N];
  int   msg    [N];
  int   mdl_ext[N];
  int   mdl_bit[N];
  bit   hard_chk;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  siso_maxlog #(.W(W), .N(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_valid (valid),
    .i_sys   (sys),
    .i_par   (par),
    .i_apr   (apr),
    .o_ready (ready),
    .o_valid (out_valid),
    .o_ext   (ext),
    .o_bit   (hard),
    .o_idx   (idx),
    .o_busy  (busy),
    .o_done  (done)
  );

  task automatic checkOutput(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int tbNext(input int s, input int u);
    int a;
    a = u ^ (s >> 1) ^ (s & 1);
    return (a << 1) | (s >> 1);
  endfunction

  function automatic int tbPar(input int s, input int u);
    int a;
    a = u ^ (s >> 1) ^ (s & 1);
    return a ^ (s & 1);
  endfunction

  function automatic int clampi(input int x, input int lo, input int hi);
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  function automatic int gam(input int k, input int s, input int u);
    return u * (fr_sys[k] + fr_apr[k]) + tbPar(s, u) * fr_par[k];
  endfunction

  task automatic setCodeword(input logic [N-1:0] m, input int mag);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) begin
      msg[k]     = int'(m[k]);
      enc_par[k] = tbPar(s, msg[k]);
      s          = tbNext(s, msg[k]);
      fr_sys[k]  = msg[k] ? mag : -mag;
      fr_par[k]  = enc_par[k] ? mag : -mag;
      fr_apr[k]  = 0;
    end
  endtask

  // Whole-frame recursion: each new metric gathers from its two predecessors.
  task automatic computeModel();
    int al [N+1][4];
    int be [4];
    int nb [4];
    int tmp[4];
    int best, v, b0, b1, lapp;
    al[0][0] = 0;
    for (int s = 1; s < 4; s++) al[0][s] = NEG;
    for (int k = 0; k < N; k++) begin
      for (int t = 0; t < 4; t++) begin
        best = -(1 << 30);
        for (int s = 0; s < 4; s++)
          for (int u = 0; u < 2; u++)
            if (tbNext(s, u) == t) begin
              v = al[k][s] + gam(k, s, u);
              if (v > best) best = v;
            end
        tmp[t] = best;
      end
      for (int t = 0; t < 4; t++)
        al[k+1][t] = clampi(tmp[t] - tmp[0], -(2 ** (AW - 1)), 2 ** (AW - 1) - 1);
    end
    for (int s = 0; s < 4; s++) be[s] = 0;
    for (int k = N - 1; k >= 0; k--) begin
      b0 = -(1 << 30);
      b1 = -(1 << 30);
      for (int s = 0; s < 4; s++)
        for (int u = 0; u < 2; u++) begin
          v = al[k][s] + gam(k, s, u) + be[tbNext(s, u)];
          if (u == 1 && v > b1) b1 = v;
          if (u == 0 && v > b0) b0 = v;
        end
      lapp       = b1 - b0;
      mdl_ext[k] = clampi(lapp - fr_sys[k] - fr_apr[k], -(2 ** (W - 1)) + 1, 2 ** (W - 1) - 1);
      mdl_bit[k] = (lapp > 0) ? 1 : 0;
      for (int s = 0; s < 4; s++) begin
        nb[s] = gam(k, s, 0) + be[tbNext(s, 0)];
        v     = gam(k, s, 1) + be[tbNext(s, 1)];
        if (v > nb[s]) nb[s] = v;
      end
      for (int s = 0; s < 4; s++)
        be[s] = clampi(nb[s] - nb[0], -(2 ** (AW - 1)), 2 ** (AW - 1) - 1);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, out_valid, 0);
    checkOutput({tag, "_ready"}, ready, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_ext"}, ext, 0);
    checkOutput({tag, "_bit"}, hard, 0);
    checkOutput({tag, "_idx"}, idx, 0);
  endtask

  // One frame from i_start; rst_idx >= 0 pulls reset while index rst_idx is on the output.
  task automatic applyStimulus(input logic [N-1:0] gaps, input bit glitch, input int rst_idx);
    exp_t e;
    bit   seen;
    computeModel();
    exp_q.delete();
    for (int k = N - 1; k >= 0; k--) begin
      e.ext  = mdl_ext[k];
      e.hard = mdl_bit[k];
      e.idx  = k;
      exp_q.push_back(e);
    end
    start = 1'b1;
    valid = glitch;
    sys   = glitch ? 8'sd99 : 8'sd0;
    @(negedge clk);
    start = 1'b0;
    valid = 1'b0;
    checkOutput("ready_in_load", ready, 1);
    checkOutput("busy_in_load", busy, 1);
    checkOutput("done_cleared", done, 0);
    for (int k = 0; k < N; k++) begin
      if (gaps[k]) begin
        valid = 1'b0;
        @(negedge clk);
      end
      valid = 1'b1;
      sys   = W'(fr_sys[k]);
      par   = W'(fr_par[k]);
      apr   = W'(fr_apr[k]);
      start = glitch && (k == 5);
      @(negedge clk);
      start = 1'b0;
    end
    valid = 1'b0;
    seen  = 1'b0;
    for (int c = 1; c <= N + 4; c++) begin
      if (glitch && c == 4) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (rst_idx >= 0) begin
        if (out_valid && idx == IW'(rst_idx)) begin
          #1 rst_n = 1'b0;
          #1 checkAllZero("rst_mid");
          #2 rst_n = 1'b1;
          exp_q.delete();
          @(negedge clk);
          return;
        end
      end else if (done) begin
        checkOutput("done_cycle", c, N + 1);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("frame_timeout", 0, 1);
    checkOutput("outputs_drained", exp_q.size(), 0);
    checkOutput("valid_after_done", out_valid, 0);
  endtask

  always @(negedge clk) begin : compare
    exp_t e;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput($sformatf("ext[%0d]", e.idx), ext, e.ext);
        checkOutput($sformatf("bit[%0d]", e.idx), hard, e.hard);
        checkOutput($sformatf("idx[%0d]", e.idx), idx, e.idx);
        checkOutput("ready_in_bwd", ready, 0);
        if (hard_chk) checkOutput($sformatf("msg[%0d]", e.idx), hard, msg[e.idx]);
      end
    end
  end

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    valid    = 1'b0;
    sys      = '0;
    par      = '0;
    apr      = '0;
    hard_chk = 1'b0;
    #2 rst_n = 1'b0;
    #10 checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Impulse response of the 5/7 code: parity 1,1,1,0
    setCodeword(16'h0001, 16);
    checkOutput("pin_par0", enc_par[0], 1);
    checkOutput("pin_par1", enc_par[1], 1);
    checkOutput("pin_par2", enc_par[2], 1);
    checkOutput("pin_par3", enc_par[3], 0);

    $display("[TB] all-zero codeword");
    setCodeword(16'h0000, 20);
    hard_chk = 1'b1;
    applyStimulus(16'h0000, 1'b0, -1);
    checkOutput("pin_ext15", mdl_ext[15], -20);
    checkOutput("pin_ext14", mdl_ext[14], -40);
    checkOutput("pin_bit15", mdl_bit[15], 0);

    $display("[TB] codeword with input gaps");
    setCodeword(16'hB4E1, 16);
    applyStimulus(16'b0010_0100_1000_0110, 1'b0, -1);

    $display("[TB] saturated inputs");
    hard_chk = 1'b0;
    for (int k = 0; k < N; k++) begin
      fr_sys[k] = 127;
      fr_par[k] = 127;
      fr_apr[k] = 127;
    end
    applyStimulus(16'h0000, 1'b0, -1);

    $display("[TB] start pulses during LOAD and BWD");
    setCodeword(16'h3C5A, 16);
    for (int k = 0; k < N; k++) fr_apr[k] = ((k % 3) - 1) * 6;
    hard_chk = 1'b1;
    applyStimulus(16'b0000_0001_0000_1000, 1'b1, -1);

    $display("[TB] reset during backward pass");
    setCodeword(16'h9137, 24);
    applyStimulus(16'h0000, 1'b0, 7);
    applyStimulus(16'h0000, 1'b0, -1);

    $display("[TB] back-to-back frames");
    setCodeword(16'h0F0F, 30);
    applyStimulus(16'h0000, 1'b0, -1);
    hard_chk = 1'b0;
    for (int k = 0; k < N; k++) begin
      fr_sys[k] = ((k * 37) % 61) - 30;
      fr_par[k] = ((k * 23 + 11) % 53) - 26;
      fr_apr[k] = ((k * 7) % 9) - 4;
    end
    applyStimulus(16'h0000, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/siso_maxlog.md
Name: siso_maxlog

Overview:
Parametrised max-log-MAP soft-in/soft-out decoder for one constituent 4-state RSC code (feedback 7, feedforward 5 octal) of the turbo decoder. It is the successor of the fixed 8-bit Siso, generalised in LLR width and frame length, and adds a-priori input, extrinsic output, a ready/valid input handshake and a done pulse. Two instances, with the interleaver between them, form one turbo iteration.

Parameters:
W, 8, signed LLR width of inputs and extrinsic output
N, 16, frame length in information bits (≥4)
AW, W+4, signed path-metric width
IW, $clog2(N), index width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle pulse in IDLE; opens a frame
i_valid  in  1  input sample valid
i_sys  in  W  systematic channel LLR (positive means bit 1)
i_par  in  W  parity channel LLR
i_apr  in  W  a-priori LLR from the other decoder
o_ready  out  1  high in LOAD only
o_valid  out  1  extrinsic output valid
o_ext  out  W  extrinsic LLR, saturated
o_bit  out  1  hard decision, 1 when Lapp > 0
o_idx  out  IW  bit index of the current output
o_busy  out  1  high whenever state is not IDLE
o_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; alpha/beta registers cleared; sample and alpha memories are not reset.
- Trellis: state s = {s1,s0}; a = u^s1^s0; p = a^s0; next state = {a,s1}; systematic bit = u.
- Branch metric: g = u·(Ls+La) + p·Lp, sign-extended to AW.
- FSM IDLE→LOAD on i_start. i_start is ignored outside IDLE.
- LOAD: a sample is accepted on each edge with i_valid && o_ready; gaps are allowed.
  - Accepting index k stores sys/par/apr[k] and alpha_k, and updates alpha to alpha_{k+1} by 4-state ACS.
  - alpha_0 = {0, NEG, NEG, NEG}, where NEG = -(2^(AW-2)).
  - Accepting index N-1 moves to BWD.
- BWD: N cycles, k = N-1 down to 0.
  - beta_N = all 0 (unterminated trellis).
  - Each cycle: Lapp_k = max over u=1 of (alpha_k+g+beta_{k+1}) − max over u=0 of the same; beta updated to beta_k.
  - Registered outputs: o_ext = sat_W(Lapp − Ls − La); o_bit; o_idx = k; o_valid = 1.
  - Output order is N-1..0 on consecutive cycles. There is no output backpressure.
- Latency: the edge that accepts sample N-1 is edge A. o_valid is high from edge A+1 through edge A+N. At edge A+N+1, o_valid drops, o_done pulses for one cycle and the state returns to IDLE.
- A new i_start is honoured in the cycle after o_done.
- Normalisation: after every ACS, subtract the state-0 metric from all four metrics. Saturate to AW bits; arithmetic never wraps.
- Extrinsic saturation: clamp to [−2^(W-1)+1, 2^(W-1)−1]. The output is symmetric; −2^(W-1) never appears.
- Ties: equal maxima give Lapp = 0, so o_bit = 0.
- i_valid outside LOAD is ignored. i_valid with i_start in the same IDLE cycle does not accept a sample.
- Reset mid-frame: the block is immediately in IDLE with outputs 0. The next i_start begins a clean frame; no stale alpha/beta is used.

Decomposition:
- siso_pkg holds:
  - constants NEG_INF and NUM_STATES=4
  - functions next_state(s,u), parity(s,u), sat(x,w)
  - typedef metric_t (signed AW)
  - state enum {IDLE, LOAD, BWD, DONE}
- Sub-module siso_acs:
  - combinational 4-state add-compare-select plus normalisation
  - direction input selects the forward or backward trellis
  - instantiated twice: alpha path and beta path

Test Plan:
1. W=8, N=16; all-zero codeword, i_sys=i_par=−20, i_apr=0, no gaps → o_valid for 16 cycles from A+1, o_idx 15..0, all o_bit=0, all o_ext<0; o_done pulses at A+17.
2. Random 16-bit message encoded with noise-free LLRs ±16 and random i_valid gaps → o_bit matches the message at every index; o_ext matches the bit-exact C golden model.
3. Saturation: i_sys=i_par=i_apr=+127 for all bits → no wrap, all o_bit=1, o_ext ≤ 127 and never −128.
4. i_start pulsed during LOAD and during BWD → ignored, frame unaffected; o_ready=0 throughout BWD.
5. i_rst_n low for 3 ns at BWD index 7 → all outputs 0 immediately. A new frame then matches the golden model.
6. Back-to-back frames: i_start in the cycle after o_done → second frame correct, no alpha carry-over.
